// File: rtl/front_panel_pkg.sv
// Shared definitions for the front-panel compositor: object counts, sprite
// geometry, frame index constants, scheduler FSM states and the active-list
// slot record.
package front_panel_pkg;

    localparam int NUM_LEDS     = 36;
    localparam int NUM_SWITCHES = 25;
    localparam int NUM_OBJ      = NUM_LEDS + NUM_SWITCHES;
    localparam int MAX_PER_LINE = 16;
    localparam int SPRITE_W     = 32;
    localparam int SPRITE_H     = 32;
    localparam int X_W          = 11;
    localparam int Y_W          = 10;
    localparam int SPR_IDX_W    = 3;
    localparam int ROM_A_W      = 13;
    localparam int OBJ_ID_W     = 6;

    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int SLOT_W = $clog2(MAX_PER_LINE);
    localparam int CNT_W  = SLOT_W + 1;

    typedef enum logic [SPR_IDX_W-1:0] {
        SW_MID  = 3'd0,
        SW_DOWN = 3'd1,
        SW_UP   = 3'd2,
        LED_ON  = 3'd3,
        LED_OFF = 3'd4
    } frame_e;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_e;

    // Frame is not stored: it is looked up live through obj_id per pixel.
    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [ROW_W-1:0]    row;
        logic [OBJ_ID_W-1:0] obj_id;
    } obj_slot_t;

endpackage

// File: rtl/sprite_hit_select.sv
// Combinational priority match of the current pixel against the display
// bank. Lowest occupied slot that covers pix_x wins.
//   slots     in  display-bank slot records
//   count     in  number of occupied slots
//   pix_valid in  active pixel
//   pix_x     in  pixel x
//   hit       out some slot covers the pixel
//   slot_id   out winning slot
//   col       out column inside the sprite for the winning slot
module sprite_hit_select
    import front_panel_pkg::*;
(
    input  obj_slot_t [MAX_PER_LINE-1:0] slots,
    input  logic [CNT_W-1:0]             count,
    input  logic                         pix_valid,
    input  logic [X_W-1:0]               pix_x,
    output logic                         hit,
    output logic [SLOT_W-1:0]            slot_id,
    output logic [COL_W-1:0]             col
);

    logic [MAX_PER_LINE-1:0]         slot_hit;
    logic [MAX_PER_LINE-1:0][X_W:0]  e;

    // One extra bit so pix_x left of the sprite shows as negative instead of
    // wrapping into a hit near x=2047.
    for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
        assign e[s]        = {1'b0, pix_x} - {1'b0, slots[s].x};
        assign slot_hit[s] = pix_valid && (CNT_W'(s) < count) && !e[s][X_W]
                             && (e[s] < (X_W+1)'(SPRITE_W));
    end

    // Walk downward so the lowest matching slot is the last assignment.
    always_comb begin
        hit     = 1'b0;
        slot_id = '0;
        col     = '0;
        for (int s = MAX_PER_LINE-1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                hit     = 1'b1;
                slot_id = SLOT_W'(s);
                col     = e[s][COL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler. During h-blank the object table is scanned
// into the build bank; line_start swaps banks. During active video the
// display bank is matched against pix_x and one ROM address is issued per
// pixel, registered one cycle after pix_x/pix_valid.
//   clk/reset                    pixel clock, synchronous active-low reset
//   obj_wr_*                     object table write port
//   obj_frame, cursor_obj        live per-object frame and cursor selection
//   line_start, next_y           h-blank start and line to build
//   pix_valid, pix_x             current displayed pixel
//   spr_addr/spr_hit/spr_cursor  registered ROM address and hit flags
//   scan_busy                    list build in progress
//   list_ovf, scan_overrun       sticky error flags
module sprite_line_scheduler
    import front_panel_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          obj_wr_en,
    input  logic [OBJ_ID_W-1:0]           obj_wr_idx,
    input  logic [X_W-1:0]                obj_wr_x,
    input  logic [Y_W-1:0]                obj_wr_y,
    input  logic [NUM_OBJ*SPR_IDX_W-1:0]  obj_frame,
    input  logic [OBJ_ID_W-1:0]           cursor_obj,
    input  logic                          line_start,
    input  logic [Y_W-1:0]                next_y,
    input  logic                          pix_valid,
    input  logic [X_W-1:0]                pix_x,
    output logic [ROM_A_W-1:0]            spr_addr,
    output logic                          spr_hit,
    output logic                          spr_cursor,
    output logic                          scan_busy,
    output logic                          list_ovf,
    output logic                          scan_overrun
);

    scan_state_e                          state, state_nxt;
    logic [OBJ_ID_W-1:0]                  scan_idx;
    logic [Y_W-1:0]                       cur_y;
    logic [X_W-1:0]                       tbl_x [NUM_OBJ];
    logic [Y_W-1:0]                       tbl_y [NUM_OBJ];
    logic [NUM_OBJ-1:0]                   tbl_vld;
    obj_slot_t [1:0][MAX_PER_LINE-1:0]    bank;
    logic [1:0][CNT_W-1:0]                cnt;
    logic                                 disp_sel, build_sel;
    logic [Y_W:0]                         d;
    logic                                 match, room;
    obj_slot_t                            new_slot;

    logic                                 sel_hit;
    logic [SLOT_W-1:0]                    sel_id;
    logic [COL_W-1:0]                     sel_col;
    obj_slot_t                            hit_slot;
    logic [SPR_IDX_W-1:0]                 hit_frame;

    assign build_sel = ~disp_sel;
    assign scan_busy = (state == S_SCAN);

    // Object table. Only valid bits are reset; x/y are don't-care until written.
    always_ff @(posedge clk) begin
        if (!reset)
            tbl_vld <= '0;
        else if (obj_wr_en && obj_wr_idx < OBJ_ID_W'(NUM_OBJ))
            tbl_vld[obj_wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (obj_wr_en && obj_wr_idx < OBJ_ID_W'(NUM_OBJ)) begin
            tbl_x[obj_wr_idx] <= obj_wr_x;
            tbl_y[obj_wr_idx] <= obj_wr_y;
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (line_start) state_nxt = S_SCAN;
            S_SCAN:  if (!line_start && scan_idx == OBJ_ID_W'(NUM_OBJ-1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line match on the object being visited; negative d means the line is
    // above the sprite.
    assign d        = {1'b0, cur_y} - {1'b0, tbl_y[scan_idx]};
    assign match    = (state == S_SCAN) && tbl_vld[scan_idx] && !d[Y_W]
                      && (d < (Y_W+1)'(SPRITE_H));
    assign room     = (cnt[build_sel] != CNT_W'(MAX_PER_LINE));
    assign new_slot = '{x: tbl_x[scan_idx], row: d[ROW_W-1:0], obj_id: scan_idx};

    // Slot storage needs no reset: the per-bank counts define occupancy.
    always_ff @(posedge clk) begin
        if (match && room)
            bank[build_sel][cnt[build_sel][SLOT_W-1:0]] <= new_slot;
    end

    // A match in the same cycle as line_start still lands in the outgoing
    // build bank, so an overrun swaps in every object visited so far.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_idx     <= '0;
            cur_y        <= '0;
            disp_sel     <= 1'b0;
            cnt          <= '0;
            list_ovf     <= 1'b0;
            scan_overrun <= 1'b0;
        end else begin
            if (match) begin
                if (room) cnt[build_sel] <= cnt[build_sel] + CNT_W'(1);
                else      list_ovf       <= 1'b1;
            end
            if (line_start) begin
                disp_sel      <= build_sel;
                cnt[disp_sel] <= '0;
                scan_idx      <= '0;
                cur_y         <= next_y;
                if (state == S_SCAN) scan_overrun <= 1'b1;
            end else if (state == S_SCAN) begin
                scan_idx <= scan_idx + OBJ_ID_W'(1);
            end
        end
    end

    // Pixel path
    sprite_hit_select u_hit_select (
        .slots     (bank[disp_sel]),
        .count     (cnt[disp_sel]),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .hit       (sel_hit),
        .slot_id   (sel_id),
        .col       (sel_col)
    );

    assign hit_slot  = bank[disp_sel][sel_id];
    assign hit_frame = obj_frame[int'(hit_slot.obj_id)*SPR_IDX_W +: SPR_IDX_W];

    // Power-of-2 sprite size makes frame*W*H + row*W + col a plain concat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            spr_addr   <= '0;
            spr_hit    <= 1'b0;
            spr_cursor <= 1'b0;
        end else begin
            spr_hit    <= sel_hit;
            spr_cursor <= sel_hit && (hit_slot.obj_id == cursor_obj);
            if (sel_hit) spr_addr <= {hit_frame, hit_slot.row, sel_col};
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
module tb_sprite_line_scheduler;
    import front_panel_pkg::*;

    logic                         clk = 1'b0;
    logic                         reset = 1'b0;
    logic                         obj_wr_en = 1'b0;
    logic [OBJ_ID_W-1:0]          obj_wr_idx = '0;
    logic [X_W-1:0]               obj_wr_x = '0;
    logic [Y_W-1:0]               obj_wr_y = '0;
    logic [NUM_OBJ*SPR_IDX_W-1:0] obj_frame = '0;
    logic [OBJ_ID_W-1:0]          cursor_obj = '0;
    logic                         line_start = 1'b0;
    logic [Y_W-1:0]               next_y = '0;
    logic                         pix_valid = 1'b0;
    logic [X_W-1:0]               pix_x = '0;
    logic [ROM_A_W-1:0]           spr_addr;
    logic                         spr_hit, spr_cursor, scan_busy, list_ovf, scan_overrun;

    sprite_line_scheduler dut (
        .clk(clk), .reset(reset), .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx),
        .obj_wr_x(obj_wr_x), .obj_wr_y(obj_wr_y), .obj_frame(obj_frame),
        .cursor_obj(cursor_obj), .line_start(line_start), .next_y(next_y),
        .pix_valid(pix_valid), .pix_x(pix_x), .spr_addr(spr_addr), .spr_hit(spr_hit),
        .spr_cursor(spr_cursor), .scan_busy(scan_busy), .list_ovf(list_ovf),
        .scan_overrun(scan_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: object table, display/build lists as queues
    typedef struct { int id; int x; int row; } mslot_t;
    mslot_t m_disp[$];
    mslot_t m_build[$];
    int     m_x [NUM_OBJ];
    int     m_y [NUM_OBJ];
    bit     m_vld [NUM_OBJ];
    bit     m_ovf;
    int     m_last_addr;
    bit     e_hit, e_cur;
    int     e_addr;

    task automatic model_reset();
        for (int k = 0; k < NUM_OBJ; k++) m_vld[k] = 0;
        m_disp.delete();
        m_build.delete();
        m_ovf = 0;
        m_last_addr = 0;
    endtask

    // Swap lists, then build the new one visiting objects 0..nvisit-1
    task automatic model_line(int y, int nvisit);
        mslot_t s;
        m_disp = m_build;
        m_build.delete();
        for (int k = 0; k < nvisit; k++) begin
            if (m_vld[k] && y - m_y[k] >= 0 && y - m_y[k] < SPRITE_H) begin
                if (m_build.size() < MAX_PER_LINE) begin
                    s.id = k; s.x = m_x[k]; s.row = y - m_y[k];
                    m_build.push_back(s);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic model_pix(int px, bit pv);
        int e;
        e_hit = 0; e_cur = 0; e_addr = m_last_addr;
        if (pv) begin
            foreach (m_disp[i]) begin
                e = px - m_disp[i].x;
                if (!e_hit && e >= 0 && e < SPRITE_W) begin
                    e_hit  = 1;
                    e_addr = int'(obj_frame[m_disp[i].id*SPR_IDX_W +: SPR_IDX_W]) * SPRITE_W * SPRITE_H
                             + m_disp[i].row * SPRITE_W + e;
                    e_cur  = (m_disp[i].id == int'(cursor_obj));
                end
            end
        end
        m_last_addr = e_addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(int k, int f);
        obj_frame[k*SPR_IDX_W +: SPR_IDX_W] = SPR_IDX_W'(f);
    endtask

    task automatic wr_obj(int idx, int x, int y);
        obj_wr_en = 1; obj_wr_idx = OBJ_ID_W'(idx); obj_wr_x = X_W'(x); obj_wr_y = Y_W'(y);
        tick();
        obj_wr_en = 0;
        if (idx < NUM_OBJ) begin
            m_vld[idx] = 1; m_x[idx] = x; m_y[idx] = y;
        end
    endtask

    task automatic do_line(int y);
        line_start = 1; next_y = Y_W'(y);
        tick();
        line_start = 0;
        model_line(y, NUM_OBJ);
        repeat (NUM_OBJ) tick();
    endtask

    // One pixel; outputs are registered so they are valid right after the edge
    task automatic pix(int px, bit pv);
        pix_x = X_W'(px); pix_valid = pv;
        model_pix(px, pv);
        tick();
        pix_valid = 0;
    endtask

    task automatic test_reset();
        int px;
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            line_start = 1; next_y = Y_W'(i);
            tick();
        end
        line_start = 0;
        checks++;
        if (spr_hit !== 0 || spr_addr !== 0 || spr_cursor !== 0) begin
            errors++;
            $display("FAIL reset_pix: hit=%0b addr=%0d cur=%0b want all 0", spr_hit, spr_addr, spr_cursor);
        end
        checks++;
        if (scan_busy !== 0 || list_ovf !== 0 || scan_overrun !== 0) begin
            errors++;
            $display("FAIL reset_flags: busy=%0b ovf=%0b ovr=%0b want all 0", scan_busy, list_ovf, scan_overrun);
        end
        reset = 1;
        model_reset();
        do_line(20);
        do_line(20);
        for (int i = 0; i < 18; i++) begin
            px = (i == 0) ? 0 : (i == 1) ? 2047 : int'($urandom_range(0, 2047));
            pix(px, 1);
            checks++;
            if (spr_hit !== 0) begin
                errors++;
                $display("FAIL empty_table: x=%0d hit=%0b want 0", px, spr_hit);
            end
        end
    endtask

    task automatic test_single();
        set_frame(3, 3);
        wr_obj(3, 100, 50);
        do_line(55);
        do_line(56);
        pix(104, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd3236 || spr_cursor !== 0) begin
            errors++;
            $display("FAIL single_hit: hit=%0b addr=%0d cur=%0b want 1 3236 0", spr_hit, spr_addr, spr_cursor);
        end
        pix(131, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd3263) begin
            errors++;
            $display("FAIL single_right_edge: hit=%0b addr=%0d want 1 3263", spr_hit, spr_addr);
        end
        pix(132, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL single_past_edge: hit=%0b want 0", spr_hit);
        end
        pix(99, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL single_left_edge: hit=%0b want 0", spr_hit);
        end
        pix(104, 0);
        checks++;
        if (spr_hit !== 0 || spr_addr !== 13'd3263) begin
            errors++;
            $display("FAIL pix_invalid_hold: hit=%0b addr=%0d want 0 3263", spr_hit, spr_addr);
        end
    endtask

    task automatic test_boundary();
        set_frame(7, 4);
        wr_obj(7, 200, 50);
        do_line(49);
        do_line(81);
        pix(200, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL y_above: hit=%0b want 0", spr_hit);
        end
        do_line(82);
        pix(200, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd5088) begin
            errors++;
            $display("FAIL y_row31: hit=%0b addr=%0d want 1 5088", spr_hit, spr_addr);
        end
        do_line(0);
        pix(200, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL y_below: hit=%0b want 0", spr_hit);
        end
        set_frame(8, 0);
        wr_obj(8, 0, 0);
        do_line(10);
        do_line(10);
        pix(2047, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL x_wrap: hit=%0b want 0", spr_hit);
        end
        pix(0, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd320) begin
            errors++;
            $display("FAIL x_zero: hit=%0b addr=%0d want 1 320", spr_hit, spr_addr);
        end
    endtask

    task automatic test_priority();
        set_frame(5, 1);
        set_frame(40, 2);
        cursor_obj = 40;
        wr_obj(5, 300, 100);
        wr_obj(40, 300, 100);
        do_line(110);
        do_line(110);
        pix(305, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd1349 || spr_cursor !== 0) begin
            errors++;
            $display("FAIL prio_low_wins: hit=%0b addr=%0d cur=%0b want 1 1349 0", spr_hit, spr_addr, spr_cursor);
        end
        wr_obj(5, 300, 1023);
        do_line(110);
        do_line(110);
        pix(305, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd2373 || spr_cursor !== 1) begin
            errors++;
            $display("FAIL prio_removed: hit=%0b addr=%0d cur=%0b want 1 2373 1", spr_hit, spr_addr, spr_cursor);
        end
        set_frame(40, 4);
        cursor_obj = 41;
        pix(305, 1);
        checks++;
        if (spr_hit !== 1 || spr_addr !== 13'd4421 || spr_cursor !== 0) begin
            errors++;
            $display("FAIL live_frame_cursor: hit=%0b addr=%0d cur=%0b want 1 4421 0", spr_hit, spr_addr, spr_cursor);
        end
    endtask

    task automatic test_overflow();
        int exp_addr;
        checks++;
        if (list_ovf !== 0) begin
            errors++;
            $display("FAIL ovf_before: ovf=%0b want 0", list_ovf);
        end
        for (int i = 10; i < 30; i++) begin
            set_frame(i, i % 5);
            wr_obj(i, 500 + (i - 10) * 40, 400);
        end
        do_line(405);
        do_line(405);
        checks++;
        if (list_ovf !== 1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%0b want 1", list_ovf);
        end
        for (int i = 10; i < 30; i++) begin
            pix(500 + (i - 10) * 40 + 1, 1);
            exp_addr = (i % 5) * 1024 + 5 * 32 + 1;
            checks++;
            if (i < 26 ? (spr_hit !== 1 || spr_addr !== ROM_A_W'(exp_addr)) : (spr_hit !== 0)) begin
                errors++;
                $display("FAIL ovf_obj%0d: hit=%0b addr=%0d want hit=%0b addr=%0d",
                         i, spr_hit, spr_addr, i < 26, exp_addr);
            end
        end
        do_line(0);
        do_line(0);
        checks++;
        if (list_ovf !== 1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%0b want 1", list_ovf);
        end
    endtask

    task automatic test_overrun();
        checks++;
        if (scan_overrun !== 0) begin
            errors++;
            $display("FAIL overrun_before: ovr=%0b want 0", scan_overrun);
        end
        for (int i = 0; i < 12; i++) begin
            set_frame(i, i % 5);
            wr_obj(i, 1000 + i * 40, 700);
        end
        line_start = 1; next_y = Y_W'(705);
        tick();
        line_start = 0;
        model_line(705, 10);
        repeat (9) tick();
        line_start = 1;
        tick();
        line_start = 0;
        model_line(705, NUM_OBJ);
        checks++;
        if (scan_overrun !== 1 || scan_busy !== 1) begin
            errors++;
            $display("FAIL overrun_set: ovr=%0b busy=%0b want 1 1", scan_overrun, scan_busy);
        end
        repeat (NUM_OBJ) tick();
        for (int i = 0; i < 12; i++) begin
            pix(1000 + i * 40 + 3, 1);
            checks++;
            if (spr_hit !== (i < 10)) begin
                errors++;
                $display("FAIL overrun_partial_obj%0d: hit=%0b want %0b", i, spr_hit, i < 10);
            end
        end
        do_line(0);
        for (int i = 0; i < 12; i++) begin
            pix(1000 + i * 40 + 3, 1);
            checks++;
            if (spr_hit !== 1 || spr_addr !== ROM_A_W'((i % 5) * 1024 + 5 * 32 + 3)) begin
                errors++;
                $display("FAIL overrun_full_obj%0d: hit=%0b addr=%0d want 1 %0d",
                         i, spr_hit, spr_addr, (i % 5) * 1024 + 163);
            end
        end
    endtask

    task automatic test_midscan_reset();
        line_start = 1; next_y = Y_W'(705);
        tick();
        line_start = 0;
        repeat (5) tick();
        checks++;
        if (scan_busy !== 1) begin
            errors++;
            $display("FAIL midscan_busy: busy=%0b want 1", scan_busy);
        end
        reset = 0;
        tick();
        reset = 1;
        model_reset();
        checks++;
        if (scan_busy !== 0 || list_ovf !== 0 || scan_overrun !== 0 || spr_hit !== 0) begin
            errors++;
            $display("FAIL midscan_reset: busy=%0b ovf=%0b ovr=%0b hit=%0b want all 0",
                     scan_busy, list_ovf, scan_overrun, spr_hit);
        end
        pix(1003, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL bank_empty_after_reset: hit=%0b want 0", spr_hit);
        end
        do_line(705);
        do_line(705);
        pix(1003, 1);
        checks++;
        if (spr_hit !== 0) begin
            errors++;
            $display("FAIL table_cleared: hit=%0b want 0", spr_hit);
        end
    endtask

    task automatic test_random();
        int px;
        bit pv;
        cursor_obj = OBJ_ID_W'($urandom_range(0, NUM_OBJ - 1));
        for (int k = 0; k < NUM_OBJ; k++) set_frame(k, $urandom_range(0, 7));
        for (int n = 0; n < 30; n++)
            wr_obj($urandom_range(0, 63), $urandom_range(0, 700), $urandom_range(0, 80));
        for (int ln = 0; ln < 10; ln++) begin
            do_line($urandom_range(0, 100));
            checks++;
            if (list_ovf !== m_ovf) begin
                errors++;
                $display("FAIL rand_ovf: line=%0d ovf=%0b want %0b", ln, list_ovf, m_ovf);
            end
            for (int p = 0; p < 30; p++) begin
                if (p % 10 == 9) set_frame($urandom_range(0, NUM_OBJ - 1), $urandom_range(0, 7));
                px = $urandom_range(0, 760);
                pv = ($urandom_range(0, 3) != 0);
                pix(px, pv);
                checks++;
                if (spr_hit !== e_hit || spr_addr !== ROM_A_W'(e_addr) || spr_cursor !== e_cur) begin
                    errors++;
                    $display("FAIL rand_pix: x=%0d v=%0b got hit=%0b addr=%0d cur=%0b want hit=%0b addr=%0d cur=%0b",
                             px, pv, spr_hit, spr_addr, spr_cursor, e_hit, e_addr, e_cur);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_boundary();
        test_priority();
        test_overflow();
        test_overrun();
        test_midscan_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
